// File: rtl/arb_front_pkg.sv
// Shared types and helpers for the arbiter requester front end.
package arb_front_pkg;

  localparam int unsigned MaxAgents = 32;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic spurious;
    logic multi;
  } err_flags_t;

  function automatic int unsigned popcount(input logic [MaxAgents-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(MaxAgents); i++) c += 32'(v[i]);
    return c;
  endfunction

  function automatic logic is_onehot(input logic [MaxAgents-1:0] v);
    return popcount(v) == 1;
  endfunction

endpackage

// File: rtl/arb_req_front_if.sv
// Push, arbiter and dispatch signals of arb_req_front.
interface arb_req_front_if #(
  parameter int unsigned NumOfAgents = 4,
  parameter int unsigned DataWidth   = 8
);
  localparam int unsigned IdWidth = arb_front_pkg::id_width(NumOfAgents);

  logic [NumOfAgents-1:0]           push_valid;
  logic [NumOfAgents*DataWidth-1:0] push_data;
  logic [NumOfAgents-1:0]           push_ready;
  logic [NumOfAgents-1:0]           Req;
  logic [NumOfAgents-1:0]           Grant;
  logic                             out_valid;
  logic [DataWidth-1:0]             out_data;
  logic [IdWidth-1:0]               out_agent_id;
  logic                             err_clear;
  logic                             err_spurious_grant;
  logic                             err_multi_grant;

  modport slave (
    input  push_valid, push_data, Grant, err_clear,
    output push_ready, Req, out_valid, out_data, out_agent_id,
           err_spurious_grant, err_multi_grant
  );

  modport master (
    output push_valid, push_data, Grant, err_clear,
    input  push_ready, Req, out_valid, out_data, out_agent_id,
           err_spurious_grant, err_multi_grant
  );
endinterface

// File: rtl/arb_req_front_agent_fifo.sv
// Per-agent synchronous FIFO; head is visible combinationally from the read pointer.
module agent_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       push,
  input  logic [DataWidth-1:0]       push_data,
  input  logic                       pop,
  output logic [DataWidth-1:0]       head,
  output logic [$clog2(FifoDepth):0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [DataWidth-1:0] mem [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == CntWidth'(FifoDepth));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because FifoDepth is a power of two.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PtrWidth'(1);
      count <= count + CntWidth'(push_ok) - CntWidth'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/arb_req_front.sv
// Requester front end: per-agent FIFOs, request decode, grant policing and dispatch register.
module arb_req_front
  import arb_front_pkg::*;
#(
  parameter int unsigned NumOfAgents = 4,
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned FifoDepth   = 4
) (
  input logic           clk,
  input logic           rstb,
  arb_req_front_if.slave bus
);
  localparam int unsigned IdWidth  = id_width(NumOfAgents);
  localparam int unsigned CntWidth = $clog2(FifoDepth) + 1;

  logic [DataWidth-1:0]   head  [NumOfAgents];
  logic [CntWidth-1:0]    count [NumOfAgents];
  logic [NumOfAgents-1:0] full;
  logic [NumOfAgents-1:0] empty;
  logic [NumOfAgents-1:0] pop;
  logic [NumOfAgents-1:0] req;
  logic [NumOfAgents-1:0] ready;
  logic                   grant_onehot;
  logic                   multi_c;
  logic                   spurious_c;
  logic                   sel_valid;
  logic [DataWidth-1:0]   sel_data;
  logic [IdWidth-1:0]     sel_id;
  logic                   out_valid_q;
  logic [DataWidth-1:0]   out_data_q;
  logic [IdWidth-1:0]     out_id_q;
  err_flags_t             err_q;

  for (genvar g = 0; g < int'(NumOfAgents); g++) begin : g_fifo
    agent_fifo #(
      .DataWidth (DataWidth),
      .FifoDepth (FifoDepth)
    ) u_fifo (
      .clk       (clk),
      .rstb      (rstb),
      .push      (bus.push_valid[g]),
      .push_data (bus.push_data[g*DataWidth +: DataWidth]),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Request/ready are pure decodes of registered FIFO state.
  always_comb begin
    req   = '0;
    ready = '0;
    for (int i = 0; i < int'(NumOfAgents); i++) begin
      req[i]   = (count[i] != '0);
      ready[i] = ~full[i];
    end
  end

  // A multi-bit grant pops nothing; a grant to an empty agent pops nothing.
  assign grant_onehot = is_onehot(MaxAgents'(bus.Grant));
  assign multi_c      = popcount(MaxAgents'(bus.Grant)) > 1;
  assign spurious_c   = |(bus.Grant & ~req);
  assign pop          = grant_onehot ? (bus.Grant & ~empty) : '0;

  always_comb begin
    sel_valid = |pop;
    sel_data  = '0;
    sel_id    = '0;
    for (int i = 0; i < int'(NumOfAgents); i++) begin
      if (pop[i]) begin
        sel_data = head[i];
        sel_id   = IdWidth'(i);
      end
    end
  end

  // New errors take priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= sel_valid;
      if (sel_valid) begin
        out_data_q <= sel_data;
        out_id_q   <= sel_id;
      end
      err_q.spurious <= (err_q.spurious & ~bus.err_clear) | spurious_c;
      err_q.multi    <= (err_q.multi & ~bus.err_clear) | multi_c;
    end
  end

  assign bus.Req                = req;
  assign bus.push_ready         = ready;
  assign bus.out_valid          = out_valid_q;
  assign bus.out_data           = out_data_q;
  assign bus.out_agent_id       = out_id_q;
  assign bus.err_spurious_grant = err_q.spurious;
  assign bus.err_multi_grant    = err_q.multi;

endmodule

// File: tb/tb_arb_req_front.sv
// Directed plus randomized bench for arb_req_front against a queue-based reference model.
module tb_arb_req_front;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned IW = 2;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  arb_req_front_if #(.NumOfAgents(N), .DataWidth(DW)) bus ();

  arb_req_front #(.NumOfAgents(N), .DataWidth(DW), .FifoDepth(D)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per agent plus expected registered outputs.
  int unsigned     mq [N][$];
  logic            m_ov;
  logic [DW-1:0]   m_od;
  logic [IW-1:0]   m_id;
  logic            m_es;
  logic            m_em;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i] = (mq[i].size() < int'(D));
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pdat(input int a, input logic [DW-1:0] v);
    logic [N*DW-1:0] p;
    p = '0;
    p[a*DW +: DW] = v;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) mq[i].delete();
    m_ov = 1'b0; m_od = '0; m_id = '0; m_es = 1'b0; m_em = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] pv, input logic [N*DW-1:0] pd,
                            input logic [N-1:0] gnt, input logic clr);
    int pre [N];
    int ng;
    int popped;
    logic spur;
    for (int i = 0; i < int'(N); i++) pre[i] = mq[i].size();
    ng     = $countones(gnt);
    popped = -1;
    spur   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i] && pre[i] == 0) spur = 1'b1;
      if (ng == 1 && gnt[i] && pre[i] > 0) popped = i;
    end
    m_ov = (popped >= 0);
    if (popped >= 0) begin
      m_od = DW'(mq[popped].pop_front());
      m_id = IW'(popped);
    end
    for (int i = 0; i < int'(N); i++)
      if (pv[i] && pre[i] < int'(D)) mq[i].push_back(32'(pd[i*DW +: DW]));
    m_es = (m_es && !clr) || spur;
    m_em = (m_em && !clr) || (ng > 1);
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("out_data", 32'(bus.out_data), 32'(m_od));
    check("out_agent_id", 32'(bus.out_agent_id), 32'(m_id));
    check("err_spurious", 32'(bus.err_spurious_grant), 32'(m_es));
    check("err_multi", 32'(bus.err_multi_grant), 32'(m_em));
    check("req_post", 32'(bus.Req), 32'(m_req()));
  endtask

  task automatic drive(input logic [N-1:0] pv, input logic [N*DW-1:0] pd,
                       input logic [N-1:0] gnt, input logic clr);
    @(negedge clk);
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.Grant      = gnt;
    bus.err_clear  = clr;
    check("req_pre", 32'(bus.Req), 32'(m_req()));
    check("ready_pre", 32'(bus.push_ready), 32'(m_ready()));
    @(posedge clk);
    model_edge(pv, pd, gnt, clr);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [N-1:0]    pv;
    logic [N-1:0]    gnt;
    logic [N*DW-1:0] pd;
    int              rq[$];
    int              r;

    bus.push_valid = '0;
    bus.push_data  = '0;
    bus.Grant      = '0;
    bus.err_clear  = 1'b0;
    model_reset();

    // Reset values
    #12;
    check("rst_req", 32'(bus.Req), 32'h0);
    check("rst_ready", 32'(bus.push_ready), 32'hF);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_id", 32'(bus.out_agent_id), 32'h0);
    check("rst_errs", {30'h0, bus.err_spurious_grant, bus.err_multi_grant}, 32'h0);
    @(negedge clk);
    rstb = 1'b1;

    // Single push on agent 2, then grant it
    drive(4'b0100, pdat(2, 8'hA5), '0, 1'b0);
    check("t1_req", 32'(bus.Req), 32'h4);
    drive('0, '0, 4'b0100, 1'b0);
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_data", 32'(bus.out_data), 32'hA5);
    check("t1_id", 32'(bus.out_agent_id), 32'h2);
    check("t1_req_drop", 32'(bus.Req), 32'h0);
    drive('0, '0, '0, 1'b0);
    check("t1_pulse", 32'(bus.out_valid), 32'h0);

    // Fill agent 0, fifth push dropped, drain in order
    for (int k = 1; k <= 4; k++) drive(4'b0001, pdat(0, DW'(k)), '0, 1'b0);
    check("fill_ready0", 32'(bus.push_ready[0]), 32'h0);
    drive(4'b0001, pdat(0, 8'h05), '0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drive('0, '0, 4'b0001, 1'b0);
      check("fill_data", 32'(bus.out_data), 32'(k));
    end
    drive('0, '0, '0, 1'b0);
    check("fill_req0", 32'(bus.Req[0]), 32'h0);

    // Round-robin drain of two entries per agent
    drive(4'hF, {8'h31, 8'h21, 8'h11, 8'h01}, '0, 1'b0);
    drive(4'hF, {8'h32, 8'h22, 8'h12, 8'h02}, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive('0, '0, N'(1 << (k % 4)), 1'b0);
      check("rr_valid", 32'(bus.out_valid), 32'h1);
      check("rr_id", 32'(bus.out_agent_id), 32'(k % 4));
      check("rr_data", 32'(bus.out_data), 32'(16 * (k % 4) + 1 + k / 4));
    end
    check("rr_errs", {30'h0, bus.err_spurious_grant, bus.err_multi_grant}, 32'h0);

    // Spurious grant then clear
    drive('0, '0, 4'b0010, 1'b0);
    check("spur_flag", 32'(bus.err_spurious_grant), 32'h1);
    check("spur_valid", 32'(bus.out_valid), 32'h0);
    drive('0, '0, '0, 1'b1);
    check("spur_clear", 32'(bus.err_spurious_grant), 32'h0);

    // Multi-grant pops nothing
    drive(4'b1010, pdat(1, 8'h77) | pdat(3, 8'h99), '0, 1'b0);
    drive('0, '0, 4'b1010, 1'b0);
    check("multi_flag", 32'(bus.err_multi_grant), 32'h1);
    check("multi_valid", 32'(bus.out_valid), 32'h0);
    check("multi_req", 32'(bus.Req), 32'hA);
    drive('0, '0, '0, 1'b1);
    drive('0, '0, 4'b0010, 1'b0);
    check("multi_d1", 32'(bus.out_data), 32'h77);
    drive('0, '0, 4'b1000, 1'b0);
    check("multi_d3", 32'(bus.out_data), 32'h99);

    // Reset asserted mid-cycle with pending data
    drive(4'b0011, pdat(0, 8'h41) | pdat(1, 8'h51), '0, 1'b0);
    drive(4'b0011, pdat(0, 8'h42) | pdat(1, 8'h52), '0, 1'b0);
    drive('0, '0, 4'b0001, 1'b0);
    #1;
    rstb = 1'b0;
    #1;
    check("mrst_req", 32'(bus.Req), 32'h0);
    check("mrst_valid", 32'(bus.out_valid), 32'h0);
    check("mrst_ready", 32'(bus.push_ready), 32'hF);
    check("mrst_data", 32'(bus.out_data), 32'h0);
    model_reset();
    bus.Grant = '0;
    @(negedge clk);
    rstb = 1'b1;
    drive('0, '0, '0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      pv = N'($urandom);
      for (int i = 0; i < int'(N); i++) pd[i*DW +: DW] = DW'($urandom);
      rq.delete();
      for (int i = 0; i < int'(N); i++) if (mq[i].size() != 0) rq.push_back(i);
      r = int'($urandom_range(0, 9));
      if (r < 7 && rq.size() != 0) gnt = N'(1 << rq[$urandom_range(0, rq.size() - 1)]);
      else if (r == 7)            gnt = N'($urandom);
      else                        gnt = '0;
      drive(pv, pd, gnt, ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_req_front.md
# arb_req_front

Requester-side front end for the round-robin arbiter: buffers per-agent transactions, drives the arbiter's request vector, and consumes grants. Each agent pushes payloads into a private FIFO. While an agent's FIFO is non-empty, its request bit is held high. When the arbiter grants that agent, the head entry is popped and forwarded downstream tagged with the agent ID. The block also polices the grant vector and raises sticky error flags for protocol violations.

## Interface
Parameters:
- NumOfAgents, 4, number of agents; ≥2.
- DataWidth, 8, payload width per transaction.
- FifoDepth, 4, entries per agent FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rstb  in  1  reset, asynchronous, active-low.
- push_valid  in  NumOfAgents  per-agent push strobe.
- push_data  in  NumOfAgents×DataWidth  per-agent payload; agent i occupies bits [i*DataWidth +: DataWidth].
- push_ready  out  NumOfAgents  per-agent FIFO not full.
- Req  out  NumOfAgents  request vector; connects to the arbiter's In.
- Grant  in  NumOfAgents  grant vector from the arbiter.
- out_valid  out  1  one-cycle pulse; a transaction was dispatched.
- out_data  out  DataWidth  dispatched payload.
- out_agent_id  out  $clog2(NumOfAgents)  source agent of out_data.
- err_clear  in  1  synchronous clear of the error flags.
- err_spurious_grant  out  1  sticky; a grant arrived for a non-requesting agent.
- err_multi_grant  out  1  sticky; more than one grant bit was set.

## Operation
- Push: agent i accepts an entry at the edge where push_valid[i] && push_ready[i] is high. push_ready[i] = (count[i] != FifoDepth), decoded from registered count only. It has no dependency on the same-cycle Grant.
- Req[i] = (count[i] != 0), decoded from registered count. A request stays high until its last entry is granted. Req is never dropped while data is pending.
- Grant valid: Grant is onehot and Grant[i] && Req[i] is high. The head of FIFO i pops at that edge.
- Spurious grant: Grant[i] with Req[i] low. Set err_spurious_grant. Agent i does not pop.
- Multi-grant: popcount(Grant) > 1. Set err_multi_grant. No agent pops, and out_valid stays 0 next cycle.
- Simultaneous push and pop on the same agent: both take effect and count is unchanged. A full FIFO still reports push_ready=0 in that cycle.
- Error flag update: err_clear clears both flags. A new error in the same cycle wins over the clear.
- Pointer wrap: read and write pointers wrap modulo FifoDepth. count is $clog2(FifoDepth)+1 bits wide.

## Timing
- Reset values:
  - count, pointers: 0
  - Req: 0
  - push_ready: all 1
  - out_valid: 0
  - out_data: 0
  - out_agent_id: 0
  - both error flags: 0
- Reset asserted mid-operation discards all FIFO contents immediately.
- Push-to-request latency: a push at edge t gives Req high in cycle t+1.
- Grant-to-dispatch latency: a valid grant sampled at edge t gives out_valid=1 with head data and ID in cycle t+1. Outputs are registered.
- out_valid is high for exactly one cycle per pop. There is no downstream backpressure; the arbiter grants at most one agent per cycle.
- Req[i] falls in the cycle after the pop that empties FIFO i.
- out_data and out_agent_id hold their last values when out_valid=0.

## Structure
- Package arb_front_pkg:
  - localparam function for ID width ($clog2(NumOfAgents)).
  - typedef for the error-flag struct {spurious, multi}.
  - onehot/popcount check function shared with the bench checker.
- Sub-module agent_fifo: a synchronous FIFO with push/pop, count, and full/empty outputs. It is instantiated NumOfAgents times in a generate loop.
- The top level holds the grant decode, the output register, and the error flags.

## Test plan
- Reset then single push: push 0xA5 on agent 2 → Req=4'b0100 next cycle. Drive Grant=4'b0100 for one cycle → out_valid=1, out_data=0xA5, out_agent_id=2 one cycle later. Req returns to 0 in that same cycle.
- Fill agent 0: push 4 entries 0x01–0x04 → push_ready[0]=0. A fifth push is ignored. Grant agent 0 four times → data dispatched in order 0x01–0x04, then Req[0]=0.
- Round-robin drain: agents 0–3 each hold 2 entries. Grants 0,1,2,3,0,1,2,3 → eight out_valid pulses with IDs in that order. No error flags set.
- Spurious grant: all FIFOs empty, Grant=4'b0010 → err_spurious_grant=1, out_valid stays 0. err_clear → flag returns to 0 the next cycle.
- Multi-grant: agents 1 and 3 requesting, Grant=4'b1010 → err_multi_grant=1, no pop, counts unchanged.
- Reset mid-stream: agents have pending entries, assert rstb low mid-cycle → Req, out_valid, and counts are 0 immediately. After deassertion, push_ready is all 1.
